// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg: shared bus widths, stage indices and stall-mask helper
package pipeline_controller_pkg;
  localparam int ADDR_W = 32;
  localparam int STALL_W = 5;
  localparam int STAGE_PC = 0;
  localparam int STAGE_IF = 1;
  localparam int STAGE_ID = 2;
  localparam int STAGE_EX = 3;
  localparam int STAGE_MEM = 4;
  function automatic logic [STALL_W-1:0] thermo(input int s);
    thermo = STALL_W'((32'd2 << s) - 32'd1);
  endfunction
endpackage

// File: rtl/pipeline_controller_if.sv
// pipeline_controller_if: stall/redirect signals between pipeline stages and the controller
interface pipeline_controller_if;
  import pipeline_controller_pkg::*;
  logic stall_req_if;
  logic stall_req_id;
  logic stall_req_ex;
  logic stall_req_mem;
  logic if_busy;
  logic exc_req;
  logic [ADDR_W-1:0] exc_target_pc;
  logic [STALL_W-1:0] stall_vec;
  logic flush;
  logic [ADDR_W-1:0] flush_pc;
  modport master(
    output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem, if_busy, exc_req, exc_target_pc,
    input stall_vec, flush, flush_pc
  );
  modport slave(
    input stall_req_if, stall_req_id, stall_req_ex, stall_req_mem, if_busy, exc_req, exc_target_pc,
    output stall_vec, flush, flush_pc
  );
endinterface

// File: rtl/pipeline_controller_stall_encoder.sv
// pipeline_controller_stall_encoder: highest requesting stage stalls itself and every stage before it
module pipeline_controller_stall_encoder
  import pipeline_controller_pkg::*;
(
  input  logic [3:0]         req_i,
  output logic [STALL_W-1:0] stall_vec_o
);
  always_comb stall_vec_o = req_i[3] ? thermo(STAGE_MEM) :
                            req_i[2] ? thermo(STAGE_EX)  :
                            req_i[1] ? thermo(STAGE_ID)  :
                            req_i[0] ? thermo(STAGE_IF)  : '0;
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall vector, deferred flush sequencing and stall performance/hang monitoring
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_controller_if.slave ctl,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic                 stall_timeout_o
);
  typedef enum logic [1:0] {RUN, WAIT_IF, FLUSH} state_t;
  localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic timeout_q, timeout_d;
  logic [STALL_W-1:0] enc_vec, vec;
  logic stalled;
  pipeline_controller_stall_encoder u_enc (
    .req_i({ctl.stall_req_mem, ctl.stall_req_ex, ctl.stall_req_id, ctl.stall_req_if}),
    .stall_vec_o(enc_vec)
  );
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    if (state_q == RUN && ctl.exc_req) begin
      state_d = ctl.if_busy ? WAIT_IF : FLUSH;
      target_d = ctl.exc_target_pc;
    end else if (state_q == WAIT_IF && !ctl.if_busy) begin
      state_d = FLUSH;
    end else if (state_q == FLUSH) begin
      state_d = RUN;
    end
    vec = rst ? '0 : state_q == RUN ? enc_vec : state_q == WAIT_IF ? '1 : '0;
    stalled = |vec;
    cyc_d = stalled && !(&cyc_q) ? cyc_q + CNT_WIDTH'(1) : cyc_q;
    run_d = !stalled ? '0 : run_q == RUN_W'(TIMEOUT_CYCLES) ? run_q : run_q + RUN_W'(1);
    timeout_d = timeout_q | (stalled && run_q == RUN_W'(TIMEOUT_CYCLES - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      target_q <= '0;
      cyc_q <= '0;
      run_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      cyc_q <= cyc_d;
      run_q <= run_d;
      timeout_q <= timeout_d;
    end
  end
  assign ctl.stall_vec = vec;
  assign ctl.flush = state_q == FLUSH;
  assign ctl.flush_pc = target_q;
  assign stall_cycles_o = cyc_q;
  assign stall_timeout_o = timeout_q;
endmodule
